// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: FSM state encoding, data_len codes,
// busy-state codes and byte-count decode helpers.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IF_RD  = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Load lengths are byte counts, store lengths are byte count minus one.
  localparam logic [2:0] LD_BYTE = 3'd1;
  localparam logic [2:0] LD_HALF = 3'd2;
  localparam logic [2:0] LD_WORD = 3'd4;
  localparam logic [2:0] SD_BYTE = 3'd0;
  localparam logic [2:0] SD_HALF = 3'd1;
  localparam logic [2:0] SD_WORD = 3'd3;

  localparam logic [2:0] FETCH_BYTES = 3'd4;

  localparam logic [1:0] BUSY_NONE  = 2'b00;
  localparam logic [1:0] BUSY_DATA  = 2'b01;
  localparam logic [1:0] BUSY_FETCH = 2'b10;

  function automatic logic [2:0] load_bytes(input logic [2:0] code);
    case (code)
      LD_BYTE: return 3'd1;
      LD_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [2:0] store_bytes(input logic [2:0] code);
    case (code)
      SD_HALF: return 3'd2;
      SD_WORD: return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_byte_assembler.sv
// byte_assembler: collects read bytes little-endian via a right-shift register
// and right-aligns the result for 1/2/4-byte reads, zero-filling unread bits.
module byte_assembler (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  input  logic [2:0]  len_i,
  output logic [31:0] word_o
);

  logic [31:0] acc_q;
  logic [2:0]  pad_bytes;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (shift_i) begin
      acc_q <= {byte_i, acc_q[31:8]};
    end
  end

  // After N shifts the first byte sits at lane 4-N; shift it down to lane 0.
  assign pad_bytes = 3'd4 - len_i;
  assign word_o    = acc_q >> {pad_bytes, 3'b000};

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetch and data load/store onto a byte-wide RAM.
// Optional macro IO_STALL_EN holds stores to the I/O region while io_buffer_full.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0]  IO_SEL = 2'b11,
  parameter int unsigned RAM_AW = 18
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        if_read_req,
  input  logic [31:0] if_addr,
  input  logic        if_clear,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        read_mem,
  input  logic        write_mem,
  input  logic [31:0] mem_addr_to_read,
  input  logic [31:0] mem_data_to_write,
  input  logic [2:0]  data_len,
  output logic        mem_load_done,
  output logic [31:0] mem_ctrl_read_in,
  output logic [1:0]  mem_ctrl_busy_state,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  input  logic        io_buffer_full
);

  localparam logic [63:0] ADDR_MASK64 = (64'd1 << RAM_AW) - 64'd1;
  localparam logic [31:0] ADDR_MASK   = ADDR_MASK64[31:0];

  state_e      state_q;
  logic        fetch_q;
  logic [2:0]  cnt_q, cnt_d, len_q;
  logic [31:0] ram_a_q, addr_d, wdata_q;
  logic        ram_wr_q;
  logic [7:0]  ram_dout_q;
  logic        if_done_q, mem_done_q;
  logic [1:0]  busy_q;
  logic        stall;
  logic        asm_clr, asm_shift;
  logic [31:0] asm_word;

  assign cnt_d  = cnt_q + 3'd1;
  assign addr_d = ram_a_q + 32'd1;

`ifdef IO_STALL_EN
  assign stall = (state_q == ST_MEM_WR) && (ram_a_q[17:16] == IO_SEL) && io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_buffer_full & (IO_SEL != 2'b00);
  assign stall     = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      fetch_q    <= 1'b0;
      cnt_q      <= '0;
      len_q      <= '0;
      ram_a_q    <= '0;
      wdata_q    <= '0;
      ram_wr_q   <= 1'b0;
      ram_dout_q <= '0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      busy_q     <= BUSY_NONE;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (read_mem || write_mem) begin
            fetch_q <= 1'b0;
            ram_a_q <= mem_addr_to_read;
            busy_q  <= BUSY_DATA;
            if (read_mem) begin
              state_q <= ST_MEM_RD;
              len_q   <= load_bytes(data_len);
            end else begin
              state_q    <= ST_MEM_WR;
              len_q      <= store_bytes(data_len);
              ram_wr_q   <= 1'b1;
              ram_dout_q <= mem_data_to_write[7:0];
              wdata_q    <= {8'h00, mem_data_to_write[31:8]};
            end
          end else if (if_read_req && !if_clear) begin
            state_q <= ST_IF_RD;
            fetch_q <= 1'b1;
            len_q   <= FETCH_BYTES;
            ram_a_q <= if_addr;
            busy_q  <= BUSY_FETCH;
          end
        end

        // Reads spend one extra cycle after the last address to catch its byte.
        ST_IF_RD, ST_MEM_RD: begin
          if (state_q == ST_IF_RD && if_clear) begin
            state_q <= ST_IDLE;
            ram_a_q <= '0;
            busy_q  <= BUSY_NONE;
          end else if (cnt_q == len_q) begin
            state_q    <= ST_DONE;
            if_done_q  <= fetch_q;
            mem_done_q <= !fetch_q;
            busy_q     <= fetch_q ? BUSY_NONE : BUSY_DATA;
          end else begin
            cnt_q   <= cnt_d;
            ram_a_q <= (cnt_d == len_q) ? 32'd0 : addr_d;
          end
        end

        ST_MEM_WR: begin
          if (!stall) begin
            if (cnt_d == len_q) begin
              state_q    <= ST_DONE;
              mem_done_q <= 1'b1;
              ram_wr_q   <= 1'b0;
              ram_a_q    <= '0;
              ram_dout_q <= '0;
            end else begin
              cnt_q      <= cnt_d;
              ram_a_q    <= addr_d;
              ram_dout_q <= wdata_q[7:0];
              wdata_q    <= {8'h00, wdata_q[31:8]};
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          fetch_q <= 1'b0;
          busy_q  <= BUSY_NONE;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= BUSY_NONE;
        end
      endcase
    end
  end

  assign asm_clr   = (state_q == ST_IDLE);
  assign asm_shift = ((state_q == ST_IF_RD) || (state_q == ST_MEM_RD)) && (cnt_q != 3'd0);

  byte_assembler u_asm (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .clr_i   (asm_clr),
    .shift_i (asm_shift),
    .byte_i  (ram_din),
    .len_i   (len_q),
    .word_o  (asm_word)
  );

  // A flush arriving in the fetch DONE cycle still suppresses the pulse.
  assign if_done             = if_done_q & ~if_clear;
  assign if_inst             = if_done ? asm_word : 32'd0;
  assign mem_load_done       = mem_done_q;
  assign mem_ctrl_read_in    = mem_done_q ? asm_word : 32'd0;
  assign mem_ctrl_busy_state = busy_q;
  assign ram_a               = ram_a_q & ADDR_MASK;
  assign ram_wr              = ram_wr_q & ~stall;
  assign ram_dout            = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a byte-wide RAM model (read data one cycle late).
// Build with +define+IO_STALL_EN to exercise the I/O store stall.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        if_read_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_clear = 1'b0;
  logic        if_done;
  logic [31:0] if_inst;
  logic        read_mem = 1'b0;
  logic        write_mem = 1'b0;
  logic [31:0] mem_addr_to_read = '0;
  logic [31:0] mem_data_to_write = '0;
  logic [2:0]  data_len = '0;
  logic        mem_load_done;
  logic [31:0] mem_ctrl_read_in;
  logic [1:0]  mem_ctrl_busy_state;
  logic [7:0]  ram_din = '0;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        io_buffer_full = 1'b0;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [7:0]  mem [0:262143];
  logic [31:0] wlog_a [$];
  logic [7:0]  wlog_d [$];

  mem_ctrl #(.IO_SEL(2'b11), .RAM_AW(18)) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .if_read_req         (if_read_req),
    .if_addr             (if_addr),
    .if_clear            (if_clear),
    .if_done             (if_done),
    .if_inst             (if_inst),
    .read_mem            (read_mem),
    .write_mem           (write_mem),
    .mem_addr_to_read    (mem_addr_to_read),
    .mem_data_to_write   (mem_data_to_write),
    .data_len            (data_len),
    .mem_load_done       (mem_load_done),
    .mem_ctrl_read_in    (mem_ctrl_read_in),
    .mem_ctrl_busy_state (mem_ctrl_busy_state),
    .ram_din             (ram_din),
    .ram_dout            (ram_dout),
    .ram_a               (ram_a),
    .ram_wr              (ram_wr),
    .io_buffer_full      (io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    ram_din <= mem[ram_a[17:0]];
    if (ram_wr) begin
      mem[ram_a[17:0]] <= ram_dout;
      wlog_a.push_back(ram_a);
      wlog_d.push_back(ram_dout);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Drives one data-stage request for a single cycle, then changes the inputs
  // to garbage and observes up to 12 cycles.
  task automatic run_data(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] len,
                          output int done_cyc, output int n_done,
                          output logic [31:0] word, output logic [1:0] busy1);
    wlog_a.delete();
    wlog_d.delete();
    read_mem = rd; write_mem = wr; mem_addr_to_read = addr;
    mem_data_to_write = data; data_len = len;
    done_cyc = 0; n_done = 0; word = '0; busy1 = '0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin
        busy1 = mem_ctrl_busy_state;
        read_mem = 1'b0; write_mem = 1'b0;
        mem_addr_to_read = 32'h0000_0999; mem_data_to_write = '0; data_len = 3'd0;
      end
      if (mem_load_done) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc = c;
          word = mem_ctrl_read_in;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (3) tick();
    chk_cnt++; if (if_done !== 1'b0) $display("FAIL reset_if_done: got %b want 0", if_done); else pass_cnt++;
    chk_cnt++; if (mem_load_done !== 1'b0) $display("FAIL reset_mem_done: got %b want 0", mem_load_done); else pass_cnt++;
    chk_cnt++; if (mem_ctrl_busy_state !== 2'b00) $display("FAIL reset_busy: got %b want 00", mem_ctrl_busy_state); else pass_cnt++;
    chk_cnt++; if (ram_a !== 32'd0) $display("FAIL reset_ram_a: got %h want 0", ram_a); else pass_cnt++;
    chk_cnt++; if (ram_wr !== 1'b0) $display("FAIL reset_ram_wr: got %b want 0", ram_wr); else pass_cnt++;
    chk_cnt++; if (if_inst !== 32'd0) $display("FAIL reset_if_inst: got %h want 0", if_inst); else pass_cnt++;
    rst_in = 1'b1;
    tick();
    $display("reset: released");
  endtask

  task automatic test_if_read();
    int done_cyc = 0, n_done = 0, addr_err = 0;
    logic [31:0] inst = '0;
    logic [1:0] busy1 = '0;
    mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h00; mem[32'h103] = 8'h00;
    if_addr = 32'h100; if_read_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin if_read_req = 1'b0; busy1 = mem_ctrl_busy_state; end
      if (c <= 4 && ram_a !== 32'h100 + 32'(c - 1)) addr_err++;
      if (c == 5 && ram_a !== 32'd0) addr_err++;
      if (if_done) begin
        n_done++;
        if (done_cyc == 0) begin done_cyc = c; inst = if_inst; end
      end
    end
    chk_cnt++; if (done_cyc != 6) $display("FAIL ifrd_done_cycle: got %0d want 6", done_cyc); else pass_cnt++;
    chk_cnt++; if (inst !== 32'h0000_0513) $display("FAIL ifrd_inst: got %h want 00000513", inst); else pass_cnt++;
    chk_cnt++; if (n_done != 1) $display("FAIL ifrd_pulses: got %0d want 1", n_done); else pass_cnt++;
    chk_cnt++; if (busy1 !== 2'b10) $display("FAIL ifrd_busy: got %b want 10", busy1); else pass_cnt++;
    chk_cnt++; if (addr_err != 0) $display("FAIL ifrd_addr_seq: got %0d bad cycles want 0", addr_err); else pass_cnt++;
    $display("if_read: addr=100 done_cyc=%0d inst=%h", done_cyc, inst);
  endtask

  task automatic test_loads();
    int done_cyc, n_done;
    logic [31:0] word;
    logic [1:0] busy1;
    mem[32'h20] = 8'h80; mem[32'h21] = 8'hFF;
    run_data(1'b1, 1'b0, 32'h20, 32'h0, 3'd1, done_cyc, n_done, word, busy1);
    chk_cnt++; if (done_cyc != 3) $display("FAIL lb_done_cycle: got %0d want 3", done_cyc); else pass_cnt++;
    chk_cnt++; if (word !== 32'h0000_0080) $display("FAIL lb_data: got %h want 00000080", word); else pass_cnt++;
    chk_cnt++; if (busy1 !== 2'b01) $display("FAIL lb_busy: got %b want 01", busy1); else pass_cnt++;
    chk_cnt++; if (n_done != 1) $display("FAIL lb_pulses: got %0d want 1", n_done); else pass_cnt++;
    $display("lb: addr=20 done_cyc=%0d data=%h", done_cyc, word);

    mem[32'h22] = 8'h34; mem[32'h23] = 8'h12;
    run_data(1'b1, 1'b0, 32'h22, 32'h0, 3'd2, done_cyc, n_done, word, busy1);
    chk_cnt++; if (done_cyc != 4) $display("FAIL lh_done_cycle: got %0d want 4", done_cyc); else pass_cnt++;
    chk_cnt++; if (word !== 32'h0000_1234) $display("FAIL lh_data: got %h want 00001234", word); else pass_cnt++;
    $display("lh: addr=22 done_cyc=%0d data=%h", done_cyc, word);

    run_data(1'b1, 1'b0, 32'h100, 32'h0, 3'd3, done_cyc, n_done, word, busy1);
    chk_cnt++; if (done_cyc != 6) $display("FAIL lbad_done_cycle: got %0d want 6", done_cyc); else pass_cnt++;
    chk_cnt++; if (word !== 32'h0000_0513) $display("FAIL lbad_data: got %h want 00000513", word); else pass_cnt++;
    $display("load len=3: addr=100 done_cyc=%0d data=%h", done_cyc, word);
  endtask

  task automatic test_stores();
    int done_cyc, n_done, werr;
    logic [31:0] word;
    logic [1:0] busy1;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    run_data(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 3'd3, done_cyc, n_done, word, busy1);
    werr = 0;
    for (int i = 0; i < 4; i++) begin
      if (wlog_a[i] !== 32'h40 + 32'(i) || wlog_d[i] !== exp_b[i]) werr++;
    end
    chk_cnt++; if (done_cyc != 5) $display("FAIL sw_done_cycle: got %0d want 5", done_cyc); else pass_cnt++;
    chk_cnt++; if (wlog_a.size() != 4) $display("FAIL sw_write_count: got %0d want 4", wlog_a.size()); else pass_cnt++;
    chk_cnt++; if (werr != 0) $display("FAIL sw_bytes: got %0d bad writes want 0", werr); else pass_cnt++;
    chk_cnt++; if (busy1 !== 2'b01) $display("FAIL sw_busy: got %b want 01", busy1); else pass_cnt++;
    $display("sw: addr=40 data=deadbeef done_cyc=%0d writes=%0d", done_cyc, wlog_a.size());

    run_data(1'b0, 1'b1, 32'h50, 32'h1122_3344, 3'd5, done_cyc, n_done, word, busy1);
    chk_cnt++; if (done_cyc != 2) $display("FAIL sbad_done_cycle: got %0d want 2", done_cyc); else pass_cnt++;
    chk_cnt++; if (wlog_a.size() != 1) $display("FAIL sbad_write_count: got %0d want 1", wlog_a.size()); else pass_cnt++;
    chk_cnt++; if (mem[32'h50] !== 8'h44) $display("FAIL sbad_byte: got %h want 44", mem[32'h50]); else pass_cnt++;
    $display("store len=5: addr=50 done_cyc=%0d writes=%0d", done_cyc, wlog_a.size());
  endtask

  task automatic test_priority();
    int mdone = 0, fdone = 0;
    logic [1:0] busy1 = '0, busy5 = '0;
    logic [31:0] mword = '0, inst = '0;
    if_addr = 32'h100; if_read_req = 1'b1;
    mem_addr_to_read = 32'h20; data_len = 3'd1; read_mem = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) begin busy1 = mem_ctrl_busy_state; read_mem = 1'b0; end
      if (c == 5) begin busy5 = mem_ctrl_busy_state; if_read_req = 1'b0; end
      if (mem_load_done && mdone == 0) begin mdone = c; mword = mem_ctrl_read_in; end
      if (if_done && fdone == 0) begin fdone = c; inst = if_inst; end
    end
    chk_cnt++; if (busy1 !== 2'b01) $display("FAIL prio_busy_data: got %b want 01", busy1); else pass_cnt++;
    chk_cnt++; if (mdone != 3) $display("FAIL prio_data_done: got %0d want 3", mdone); else pass_cnt++;
    chk_cnt++; if (mword !== 32'h80) $display("FAIL prio_data_word: got %h want 00000080", mword); else pass_cnt++;
    chk_cnt++; if (busy5 !== 2'b10) $display("FAIL prio_busy_fetch: got %b want 10", busy5); else pass_cnt++;
    chk_cnt++; if (fdone != 10) $display("FAIL prio_fetch_done: got %0d want 10", fdone); else pass_cnt++;
    chk_cnt++; if (inst !== 32'h0000_0513) $display("FAIL prio_inst: got %h want 00000513", inst); else pass_cnt++;
    $display("priority: data_done=%0d fetch_done=%0d", mdone, fdone);
  endtask

  task automatic test_if_clear();
    int n_done = 0, done_cyc = 0;
    logic [1:0] busy3 = '0;
    logic [31:0] first_a = '0, inst = '0;
    if_addr = 32'h100; if_read_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) if_read_req = 1'b0;
      if (c == 2) if_clear = 1'b1;
      if (c == 3) begin if_clear = 1'b0; busy3 = mem_ctrl_busy_state; end
      if (if_done) n_done++;
    end
    chk_cnt++; if (n_done != 0) $display("FAIL clr_no_done: got %0d pulses want 0", n_done); else pass_cnt++;
    chk_cnt++; if (busy3 !== 2'b00) $display("FAIL clr_busy: got %b want 00", busy3); else pass_cnt++;

    mem[32'h200] = 8'h67; mem[32'h201] = 8'h45; mem[32'h202] = 8'h23; mem[32'h203] = 8'h01;
    if_addr = 32'h200; if_read_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin if_read_req = 1'b0; first_a = ram_a; end
      if (if_done && done_cyc == 0) begin done_cyc = c; inst = if_inst; end
    end
    chk_cnt++; if (first_a !== 32'h200) $display("FAIL clr_fresh_addr: got %h want 00000200", first_a); else pass_cnt++;
    chk_cnt++; if (inst !== 32'h0123_4567) $display("FAIL clr_fresh_inst: got %h want 01234567", inst); else pass_cnt++;
    chk_cnt++; if (done_cyc != 6) $display("FAIL clr_fresh_done: got %0d want 6", done_cyc); else pass_cnt++;
    $display("if_clear: aborted pulses=%0d refetch inst=%h", n_done, inst);
  endtask

  task automatic test_clear_in_done();
    logic seen = 1'b0;
    int n_done = 0;
    if_addr = 32'h100; if_read_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) if_read_req = 1'b0;
      if (c == 6) begin if_clear = 1'b1; #1; seen = if_done; end
      if (c == 7) if_clear = 1'b0;
      if (if_done) n_done++;
    end
    chk_cnt++; if (seen !== 1'b0) $display("FAIL clrdone_gate: got %b want 0", seen); else pass_cnt++;
    chk_cnt++; if (n_done != 0) $display("FAIL clrdone_pulses: got %0d want 0", n_done); else pass_cnt++;
    $display("clear_in_done: if_done=%b", seen);
  endtask

  task automatic test_io_stall();
    int done_cyc = 0, early_wr = 0;
    logic wr_rel = 1'b0;
    logic [31:0] a_rel = '0;
    wlog_a.delete();
    wlog_d.delete();
    io_buffer_full = 1'b1;
    write_mem = 1'b1; mem_addr_to_read = 32'h0003_0000; mem_data_to_write = 32'h0000_00A5;
    data_len = 3'd0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) write_mem = 1'b0;
`ifdef IO_STALL_EN
      if (c == 4) begin io_buffer_full = 1'b0; #1; end
      if (c <= 3 && ram_wr) early_wr++;
      if (c == 4) begin wr_rel = ram_wr; a_rel = ram_a; end
`else
      if (c == 1) begin wr_rel = ram_wr; a_rel = ram_a; end
`endif
      if (mem_load_done && done_cyc == 0) done_cyc = c;
    end
    io_buffer_full = 1'b0;
`ifdef IO_STALL_EN
    chk_cnt++; if (early_wr != 0) $display("FAIL stall_held: got %0d write cycles want 0", early_wr); else pass_cnt++;
    chk_cnt++; if (done_cyc != 5) $display("FAIL stall_done: got %0d want 5", done_cyc); else pass_cnt++;
`else
    chk_cnt++; if (done_cyc != 2) $display("FAIL nostall_done: got %0d want 2", done_cyc); else pass_cnt++;
`endif
    chk_cnt++; if (wr_rel !== 1'b1) $display("FAIL io_wr: got %b want 1", wr_rel); else pass_cnt++;
    chk_cnt++; if (a_rel !== 32'h0003_0000) $display("FAIL io_addr: got %h want 00030000", a_rel); else pass_cnt++;
    chk_cnt++; if (mem[32'h30000] !== 8'hA5) $display("FAIL io_byte: got %h want a5", mem[32'h30000]); else pass_cnt++;
    $display("io_store: addr=30000 done_cyc=%0d", done_cyc);
  endtask

  task automatic test_reset_mid();
    wlog_a.delete();
    wlog_d.delete();
    write_mem = 1'b1; mem_addr_to_read = 32'h60; mem_data_to_write = 32'h4433_2211;
    data_len = 3'd3;
    tick();
    write_mem = 1'b0;
    tick();
    rst_in = 1'b0;
    #1;
    chk_cnt++; if (ram_wr !== 1'b0) $display("FAIL rstmid_ram_wr: got %b want 0", ram_wr); else pass_cnt++;
    chk_cnt++; if (ram_a !== 32'd0) $display("FAIL rstmid_ram_a: got %h want 0", ram_a); else pass_cnt++;
    chk_cnt++; if (mem_ctrl_busy_state !== 2'b00) $display("FAIL rstmid_busy: got %b want 00", mem_ctrl_busy_state); else pass_cnt++;
    tick();
    rst_in = 1'b1;
    repeat (3) tick();
    chk_cnt++; if (wlog_a.size() != 1) $display("FAIL rstmid_partial: got %0d writes want 1", wlog_a.size()); else pass_cnt++;
    chk_cnt++; if (mem[32'h61] !== 8'h00) $display("FAIL rstmid_byte1: got %h want 00", mem[32'h61]); else pass_cnt++;
    $display("reset_mid: writes=%0d", wlog_a.size());
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_loads();
    test_stores();
    test_priority();
    test_if_clear();
    test_clear_in_done();
    test_io_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
